// File: rtl/spoke_ring_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : spoke_ring_renderer_if
// Brief    : Control, pixel and result signals of the spoke ring renderer.
// Revision : 1.0 - initial release
// ============================================================================
interface spoke_ring_renderer_if #(
  parameter int N_SPOKES   = 2,
  parameter int ANGLE_BITS = 8
);
  logic                  frame_start;
  logic                  enable;
  logic                  dir;
  logic [ANGLE_BITS-1:0] speed;
  logic [9:0]            centerX;
  logic [9:0]            centerY;
  logic [9:0]            radius;
  logic [9:0]            drawX;
  logic [9:0]            drawY;
  logic                  busy;
  logic [N_SPOKES-1:0]   showSpoke;
  logic                  showTip;

  modport master (
    output frame_start, enable, dir, speed, centerX, centerY, radius, drawX, drawY,
    input  busy, showSpoke, showTip
  );

  modport slave (
    input  frame_start, enable, dir, speed, centerX, centerY, radius, drawX, drawY,
    output busy, showSpoke, showTip
  );
endinterface
`default_nettype wire

// File: rtl/spoke_ring_renderer.sv
`default_nettype none
// ============================================================================
// Module   : spoke_ring_renderer
// Brief    : Rotating multi-spoke ball sprite; per-frame ball table + 2-cycle hit test.
// Revision : 1.0 - initial release
// ============================================================================
module spoke_ring_renderer #(
  parameter int N_SPOKES        = 2,
  parameter int BALLS_PER_SPOKE = 8,
  parameter int BALL_SPACING    = 10,
  parameter int BALL_R2         = 64,
  parameter int TIP_R2          = 121,
  parameter int ANGLE_BITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  spoke_ring_renderer_if.slave bus
);
  localparam int ENTRIES = N_SPOKES * BALLS_PER_SPOKE;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int S_W     = (N_SPOKES > 1) ? $clog2(N_SPOKES) : 1;
  localparam int K_W     = (BALLS_PER_SPOKE > 1) ? $clog2(BALLS_PER_SPOKE) : 1;
  localparam logic [ANGLE_BITS-1:0] c_step = ANGLE_BITS'((1 << ANGLE_BITS) / N_SPOKES);

  // First quadrant of 256*sin, 256 steps per turn; other quadrants by symmetry.
  localparam logic [8:0] c_sinTab [65] = '{
    9'd0,   9'd6,   9'd13,  9'd19,  9'd25,  9'd31,  9'd38,  9'd44,  9'd50,  9'd56,
    9'd62,  9'd68,  9'd74,  9'd80,  9'd86,  9'd92,  9'd98,  9'd104, 9'd109, 9'd115,
    9'd121, 9'd126, 9'd132, 9'd137, 9'd142, 9'd147, 9'd152, 9'd157, 9'd162, 9'd167,
    9'd172, 9'd177, 9'd181, 9'd185, 9'd190, 9'd194, 9'd198, 9'd202, 9'd206, 9'd209,
    9'd213, 9'd216, 9'd220, 9'd223, 9'd226, 9'd229, 9'd231, 9'd234, 9'd237, 9'd239,
    9'd241, 9'd243, 9'd245, 9'd247, 9'd248, 9'd250, 9'd251, 9'd252, 9'd253, 9'd254,
    9'd255, 9'd255, 9'd256, 9'd256, 9'd256
  };

  function automatic logic signed [9:0] sinQ(input logic [7:0] a);
    logic [6:0] j;
    logic [9:0] mag;
    j   = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    mag = {1'b0, c_sinTab[j]};
    return a[7] ? -$signed(mag) : $signed(mag);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2
  } state_t;

  state_t r_state, w_stateNext;
  logic   w_busy;

  logic [ANGLE_BITS-1:0] r_angle;
  logic [9:0]            r_cx, r_cy, r_radius;
  logic                  r_issue;
  logic [S_W-1:0]        r_s;
  logic [K_W-1:0]        r_k;
  logic [IDX_W-1:0]      r_idx;

  logic                  r_p1Valid;
  logic [IDX_W-1:0]      r_p1Idx;
  logic signed [9:0]     r_p1Cos, r_p1Sin;
  logic signed [11:0]    r_p1R;
  logic                  r_p2Valid;
  logic [IDX_W-1:0]      r_p2Idx;
  logic signed [11:0]    r_p2Ox, r_p2Oy;
  logic                  r_p2RPos;

  logic [ENTRIES-1:0]    r_tValid;
  logic [9:0]            r_tX [ENTRIES];
  logic [9:0]            r_tY [ENTRIES];

  logic [ANGLE_BITS-1:0] w_issueAngle;
  logic [7:0]            w_lutAngle;
  logic signed [11:0]    w_issueR;
  logic signed [21:0]    w_mulC, w_mulS;
  logic signed [11:0]    w_wrX, w_wrY;
  logic                  w_wrOk;

  assign w_issueAngle = r_angle + ANGLE_BITS'(r_s) * c_step;
  assign w_issueR     = 12'({2'b00, r_radius}) - 12'(int'(r_k) * BALL_SPACING);

  // The LUT is built for 256 steps per turn; other resolutions are rescaled.
  if (ANGLE_BITS >= 8) begin : g_angleDown
    assign w_lutAngle = w_issueAngle[ANGLE_BITS-1 -: 8];
  end else begin : g_angleUp
    assign w_lutAngle = {w_issueAngle, (8-ANGLE_BITS)'(0)};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.frame_start) w_stateNext = ST_LOAD;
      end
      ST_LOAD: w_stateNext = ST_CALC;
      ST_CALC: if (r_p2Valid && r_p2Idx == IDX_W'(ENTRIES-1)) w_stateNext = ST_IDLE;
      default: begin
        w_busy      = 1'b0;
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Frame latch and ball issue counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_angle  <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_radius <= '0;
      r_issue  <= 1'b0;
      r_s      <= '0;
      r_k      <= '0;
      r_idx    <= '0;
    end else if (r_state == ST_LOAD) begin
      r_cx     <= bus.centerX;
      r_cy     <= bus.centerY;
      r_radius <= bus.radius;
      if (bus.enable) r_angle <= bus.dir ? (r_angle - bus.speed) : (r_angle + bus.speed);
      r_issue  <= 1'b1;
      r_s      <= '0;
      r_k      <= '0;
      r_idx    <= '0;
    end else if (r_issue) begin
      r_idx <= r_idx + 1'b1;
      if (r_k == K_W'(BALLS_PER_SPOKE-1)) begin
        r_k <= '0;
        r_s <= r_s + 1'b1;
        if (r_s == S_W'(N_SPOKES-1)) r_issue <= 1'b0;
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  assign w_mulC = r_p1R * r_p1Cos;
  assign w_mulS = r_p1R * r_p1Sin;
  assign w_wrX  = $signed({2'b00, r_cx}) + r_p2Ox;
  assign w_wrY  = $signed({2'b00, r_cy}) - r_p2Oy;
  assign w_wrOk = r_p2RPos && (w_wrX[11:10] == 2'b00) && (w_wrY[11:10] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1Valid <= 1'b0;
      r_p1Idx   <= '0;
      r_p1Cos   <= '0;
      r_p1Sin   <= '0;
      r_p1R     <= '0;
      r_p2Valid <= 1'b0;
      r_p2Idx   <= '0;
      r_p2Ox    <= '0;
      r_p2Oy    <= '0;
      r_p2RPos  <= 1'b0;
      r_tValid  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tX[i] <= '0;
        r_tY[i] <= '0;
      end
    end else begin
      r_p1Valid <= r_issue;
      r_p1Idx   <= r_idx;
      r_p1Cos   <= sinQ(w_lutAngle + 8'd64);
      r_p1Sin   <= sinQ(w_lutAngle);
      r_p1R     <= w_issueR;
      r_p2Valid <= r_p1Valid;
      r_p2Idx   <= r_p1Idx;
      r_p2Ox    <= 12'(w_mulC >>> 8);
      r_p2Oy    <= 12'(w_mulS >>> 8);
      r_p2RPos  <= (r_p1R > 12'sd0);
      if (r_p2Valid) begin
        r_tValid[r_p2Idx] <= w_wrOk;
        r_tX[r_p2Idx]     <= w_wrX[9:0];
        r_tY[r_p2Idx]     <= w_wrY[9:0];
      end
    end
  end

  logic [ENTRIES-1:0] w_hit;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    localparam int c_r2 = ((i % BALLS_PER_SPOKE) == 0) ? TIP_R2 : BALL_R2;
    logic signed [10:0] r_dx, r_dy;
    logic               r_hit;
    logic signed [21:0] w_sqX, w_sqY;
    logic [22:0]        w_d2;

    assign w_sqX = r_dx * r_dx;
    assign w_sqY = r_dy * r_dy;
    assign w_d2  = 23'($unsigned(w_sqX)) + 23'($unsigned(w_sqY));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dx  <= '0;
        r_dy  <= '0;
        r_hit <= 1'b0;
      end else begin
        r_dx  <= $signed({1'b0, bus.drawX}) - $signed({1'b0, r_tX[i]});
        r_dy  <= $signed({1'b0, bus.drawY}) - $signed({1'b0, r_tY[i]});
        r_hit <= (w_d2 <= 23'(c_r2)) && r_tValid[i];
      end
    end
    assign w_hit[i] = r_hit;
  end

  logic [N_SPOKES-1:0] w_spoke;
  logic                w_tip;

  always_comb begin
    w_spoke = '0;
    w_tip   = 1'b0;
    for (int s = 0; s < N_SPOKES; s++) begin
      w_spoke[s] = |w_hit[s*BALLS_PER_SPOKE +: BALLS_PER_SPOKE];
      w_tip      = w_tip | w_hit[s*BALLS_PER_SPOKE];
    end
  end

  // Table contents are mid-rewrite while busy, so the outputs are blanked.
  assign bus.busy      = w_busy;
  assign bus.showSpoke = w_busy ? '0 : w_spoke;
  assign bus.showTip   = w_busy ? 1'b0 : w_tip;
endmodule
`default_nettype wire
